// File: rtl/paralel_word_fifo.sv
`default_nettype none
// ============================================================================
// Module      : paralel_word_fifo
// Description : Receive-side word FIFO behind the serial-to-parallel
//               converter. It captures P_IN on each P_VALID strobe and
//               delivers the words over a valid/ready handshake. It also
//               provides a sticky overflow flag and a 16-bit accepted-word
//               counter for link diagnostics.
// Revision    : 1.0 - initial release
// ============================================================================
module paralel_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             P_VALID,
    input  logic [WIDTH-1:0] P_IN,
    input  logic             D_READY,
    input  logic             CLR_OVF,
    output logic [WIDTH-1:0] D_OUT,
    output logic             D_VALID,
    output logic [AW:0]      COUNT,
    output logic             FULL,
    output logic             EMPTY,
    output logic             OVERFLOW,
    output logic [15:0]      WORD_CNT
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [AW:0]   c_depth   = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   c_cnt_one = (AW + 1)'(1);
    localparam logic [AW-1:0] c_ptr_one = AW'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [AW:0]   count_q,    count_d;
    logic          ovf_q,      ovf_d;
    logic [15:0]   word_cnt_q, word_cnt_d;

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // Flags come from the registered occupancy only, so they never glitch
    // on input activity.
    always_comb begin
        w_full  = (count_q == c_depth);
        w_empty = (count_q == '0);
        w_pop   = ~w_empty & D_READY;
        // A full FIFO still accepts a word when the head leaves in the
        // same cycle, so the slot freed by the pop is reused at once.
        w_push  = P_VALID & (~w_full | w_pop);
        w_drop  = P_VALID & w_full & ~w_pop;
    end

    // ------------------------------------------------------------------------
    // Next-state logic for pointers, occupancy, overflow and word counter
    // ------------------------------------------------------------------------
    // Compute the next pointers, occupancy, overflow flag and word count.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        word_cnt_d = word_cnt_q;

        if (w_push) begin
            // Pointers are AW bits wide and DEPTH is a power of two, so the
            // natural overflow of the adder is the modulo-DEPTH wrap.
            wr_ptr_d   = wr_ptr_q + c_ptr_one;
            word_cnt_d = word_cnt_q + 16'd1;
        end

        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_one;
        end

        // Occupancy moves only when exactly one side is active.
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_cnt_one;
            2'b01:   count_d = count_q - c_cnt_one;
            default: count_d = count_q;
        endcase

        // The clear is applied first so that a drop in the same cycle wins.
        if (CLR_OVF) begin
            ovf_d = 1'b0;
        end
        if (w_drop) begin
            ovf_d = 1'b1;
        end
    end

    // Compute the next memory contents; only the slot at wr_ptr changes.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (w_push) begin
            mem_d[wr_ptr_q] = P_IN;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // Control state, cleared asynchronously whenever RESET is low.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // Data storage; left unreset because the empty flag masks stale words.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // Drive the status outputs; D_OUT is forced to zero while empty so the
    // consumer never sees stale or uninitialised storage.
    always_comb begin
        COUNT    = count_q;
        FULL     = w_full;
        EMPTY    = w_empty;
        D_VALID  = ~w_empty;
        OVERFLOW = ovf_q;
        WORD_CNT = word_cnt_q;
        D_OUT    = w_empty ? '0 : mem_q[rd_ptr_q];
    end

endmodule
`default_nettype wire

// File: doc/paralel_word_fifo.md
# paralel_word_fifo

Receive-side buffer that sits directly downstream of the serial-to-parallel converter. It captures every 32-bit word presented on the converter's `P_OUT`/`P_VALID` pair into a small synchronous FIFO. It hands the words to the consumer over a valid/ready handshake. Overflow is reported with a sticky flag, and a free-running accepted-word counter is kept for link diagnostics.

## Interface
- `WIDTH`, 32: word width; matches the converter's parallel output.
- `DEPTH`, 4: FIFO entries; must be a power of two, minimum 2.
- `AW`, 2: pointer width, equal to log2(`DEPTH`).
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RESET` in 1: asynchronous, active-low reset (0 = reset asserted).
- `P_VALID` in 1: one-cycle strobe from the converter; word on `P_IN` is valid.
- `P_IN` in `WIDTH`: parallel word from the converter.
- `D_READY` in 1: consumer can take `D_OUT` this cycle.
- `CLR_OVF` in 1: synchronous clear of `OVERFLOW`.
- `D_OUT` out `WIDTH`: head-of-FIFO word.
- `D_VALID` out 1: `D_OUT` holds a valid word.
- `COUNT` out `AW`+1: number of stored words, 0..`DEPTH`.
- `FULL` out 1: `COUNT` == `DEPTH`.
- `EMPTY` out 1: `COUNT` == 0.
- `OVERFLOW` out 1: sticky; a word was dropped.
- `WORD_CNT` out 16: total words accepted since reset; wraps.

## Operation
- **Storage.** `DEPTH` x `WIDTH` register array with write pointer `wr_ptr` and read pointer `rd_ptr`, each `AW` bits and wrapping modulo `DEPTH`. `COUNT` is a separate register. The memory array is not reset.
- **Pop.** `pop = D_VALID & D_READY`.
- **Push.** `push = P_VALID & (~FULL | pop)`.
  - A word arriving while full is accepted only if a pop occurs in the same cycle.
  - On push: `mem[wr_ptr] <= P_IN`, `wr_ptr` += 1, `WORD_CNT` += 1 (wraps 0xFFFF -> 0x0000).
- **Drop.** `P_VALID & FULL & ~pop`:
  - the word is discarded;
  - pointers and `COUNT` are unchanged;
  - `OVERFLOW` <= 1.
- **Pop update.** On pop, `rd_ptr` += 1.
- **COUNT update.** +1 on push only, -1 on pop only, unchanged when both or neither occur.
- **OVERFLOW.** Set on a drop, cleared by `CLR_OVF`. If a drop and `CLR_OVF` occur in the same cycle, set wins (`OVERFLOW` = 1 afterwards).
- **Outputs.**
  - `D_VALID` = ~`EMPTY`.
  - `D_OUT` = `mem[rd_ptr]` when not empty, forced to 0 when `EMPTY`.
  - `FULL` and `EMPTY` are decoded from `COUNT`.
- **No bypass.** When empty, a word pushed in cycle k cannot be popped in cycle k.
- **Consumer rules.** `D_READY` may be held high continuously. `D_OUT` stays stable while `D_VALID`=1 and `D_READY`=0.

## Timing
- **Reset.** `RESET`=0 immediately forces, independent of `CLK`:
  - `wr_ptr` = `rd_ptr` = 0;
  - `COUNT` = 0, `EMPTY` = 1, `FULL` = 0;
  - `D_VALID` = 0, `D_OUT` = 0;
  - `OVERFLOW` = 0, `WORD_CNT` = 0.
- **Reset mid-operation.** Stored words are lost. A `P_VALID` strobe coinciding with reset is ignored. After reset deasserts, the first rising edge behaves normally.
- **Latency.** A word pushed at edge k is on `D_OUT` with `D_VALID`=1 during cycle k+1 if the FIFO was empty. Otherwise it appears after all older words have been popped.
- **Throughput.** One push and one pop per cycle are sustained. `COUNT` is constant under a simultaneous push and pop.
- **Full + push + pop.** The head word leaves, the new word is written at `wr_ptr`, `FULL` stays 1, and there is no overflow.
- **Output timing.** `COUNT`, `FULL`, `EMPTY` and `D_VALID` change only on clock edges or on reset assertion.
- **Upstream rate.** The converter strobes `P_VALID` for one cycle per received word. The block also accepts back-to-back strobes on consecutive cycles.

## Test plan
- **Reset values:** assert `RESET`=0 mid-stream with `COUNT`=3 -> all outputs at reset values in the same cycle; `D_OUT`=0x00000000.
- **Single word:** push 0xDEADBEEF into the empty FIFO with `D_READY`=0 -> next cycle `D_VALID`=1, `D_OUT`=0xDEADBEEF, `COUNT`=1, `WORD_CNT`=1; then `D_READY`=1 for one cycle -> `EMPTY`=1, `D_OUT`=0.
- **Fill, overflow, drain order:**
  - push 0x1, 0x2, 0x3, 0x4 with `D_READY`=0 -> `FULL`=1, `COUNT`=4;
  - push 0x5 -> dropped, `OVERFLOW`=1, `WORD_CNT`=4;
  - drain -> 0x1, 0x2, 0x3, 0x4 in order.
- **Full with simultaneous push/pop:** with the FIFO full of 0xA0..0xA3, `P_VALID`=1 with `P_IN`=0xA4 and `D_READY`=1 -> `OVERFLOW` stays 0, `COUNT`=4; the next heads are 0xA1, 0xA2, 0xA3, 0xA4.
- **OVERFLOW priority:** a drop and `CLR_OVF`=1 in the same cycle -> `OVERFLOW`=1; `CLR_OVF` alone the next cycle -> `OVERFLOW`=0.
- **Wrap-around:** 70000 back-to-back pushes with `D_READY`=1 -> no drops, data matches in order, pointers wrap cleanly, `WORD_CNT` = 70000 mod 65536 = 4464.
